// File: rtl/key_sched_pkg.sv
// Shared constants and state type for the key command scheduler.
package key_sched_pkg;

  localparam int NKEYS        = 4;
  localparam int HOLD_CYC_DEF = 25_000_000;
  localparam int REP_CYC_DEF  = 5_000_000;
  localparam int CNT_W_DEF    = 25;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HOLD,
    REPEAT
  } rep_state_t;

endpackage

// File: rtl/key_cmd_sched_if.sv
// Command channel from the scheduler to game logic (valid/ready).
interface key_cmd_sched_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_key;
  logic       cmd_rep;

  modport master (
    output cmd_valid,
    output cmd_key,
    output cmd_rep,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_key,
    input  cmd_rep,
    output cmd_ready
  );

endinterface

// File: rtl/key_rep_fsm.sv
// Per-key press / long-press auto-repeat generator.
// Strobes ev for one cycle per event; ev_rep marks repeat events.
module key_rep_fsm
  import key_sched_pkg::*;
#(
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int REP_CYC  = REP_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk50M,
  input  logic rst,
  input  logic held,
  input  logic press,
  input  logic en,
  output logic ev,
  output logic ev_rep
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

  rep_state_t       state;
  logic [CNT_W-1:0] cnt;

  // Event is decoded from the current state so the pending slot loads on the next edge.
  always_comb begin
    ev     = 1'b0;
    ev_rep = 1'b0;
    if (en) begin
      case (state)
        IDLE:      ev = press;
        WAIT_HOLD: begin
          ev     = held && (cnt == HOLD_LAST);
          ev_rep = 1'b1;
        end
        REPEAT:    begin
          ev     = held && (cnt == REP_LAST);
          ev_rep = 1'b1;
        end
        default:   ev = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk50M) begin
    if (rst || !en) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            state <= WAIT_HOLD;
            cnt   <= '0;
          end
        end
        WAIT_HOLD: begin
          if (!held) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == HOLD_LAST) begin
            state <= REPEAT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (!held) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == REP_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_cmd_sched.sv
// Turns debounced active-low keys into press/repeat commands, arbitrated
// round-robin onto one valid/ready channel with a one-deep slot per key.
module key_cmd_sched
  import key_sched_pkg::*;
#(
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int REP_CYC  = REP_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk50M,
  input  logic             rst,
  input  logic [NKEYS-1:0] k_n,
  input  logic             en,
  key_cmd_sched_if.master  cmd,
  output logic [NKEYS-1:0] held,
  output logic [NKEYS-1:0] ovf,
  input  logic             ovf_clr
);

  logic [NKEYS-1:0] held_prev;
  logic [NKEYS-1:0] press;
  logic [NKEYS-1:0] ev;
  logic [NKEYS-1:0] ev_rep;
  logic [NKEYS-1:0] pend;
  logic [NKEYS-1:0] pend_rep;
  logic [NKEYS-1:0] take;
  logic [1:0]       rr;
  logic [1:0]       gnt_idx;
  logic             gnt_any;
  logic             load;

  // Held resets to all-pressed so a key held through reset release is not an edge.
  always_ff @(posedge clk50M) begin
    if (rst) begin
      held      <= '1;
      held_prev <= '1;
    end else begin
      held      <= ~k_n;
      held_prev <= held;
    end
  end

  assign press = held & ~held_prev;

  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    key_rep_fsm #(
      .HOLD_CYC (HOLD_CYC),
      .REP_CYC  (REP_CYC),
      .CNT_W    (CNT_W)
    ) u_fsm (
      .clk50M (clk50M),
      .rst    (rst),
      .held   (held[k]),
      .press  (press[k]),
      .en     (en),
      .ev     (ev[k]),
      .ev_rep (ev_rep[k])
    );
  end

  assign load = !cmd.cmd_valid || cmd.cmd_ready;

  // First pending key after the last winner, wrapping modulo NKEYS.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = rr;
    for (int i = 1; i <= NKEYS; i++) begin
      if (!gnt_any && pend[rr + 2'(i)]) begin
        gnt_any = 1'b1;
        gnt_idx = rr + 2'(i);
      end
    end
    take = (load && gnt_any) ? (NKEYS'(1) << gnt_idx) : '0;
  end

  // A slot being granted this cycle can take a new event without overflow.
  always_ff @(posedge clk50M) begin
    if (rst) begin
      pend     <= '0;
      pend_rep <= '0;
      ovf      <= '0;
    end else begin
      if (ovf_clr) begin
        ovf <= '0;
      end
      for (int k = 0; k < NKEYS; k++) begin
        if (ev[k]) begin
          if (!pend[k] || take[k]) begin
            pend[k]     <= 1'b1;
            pend_rep[k] <= ev_rep[k];
          end else begin
            ovf[k] <= 1'b1;
          end
        end else if (take[k]) begin
          pend[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_key   <= '0;
      cmd.cmd_rep   <= 1'b0;
      rr            <= 2'(NKEYS - 1);
    end else if (load) begin
      if (gnt_any) begin
        cmd.cmd_valid <= 1'b1;
        cmd.cmd_key   <= gnt_idx;
        cmd.cmd_rep   <= pend_rep[gnt_idx];
        rr            <= gnt_idx;
      end else begin
        cmd.cmd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_cmd_sched.sv
// Scenario and randomized checks of key_cmd_sched against a timing-rule model.
module tb_key_cmd_sched;

  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic       clk50M;
  logic       rst;
  logic [3:0] k_n;
  logic       en;
  logic       ovf_clr;
  logic [3:0] held;
  logic [3:0] ovf;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int acc_key[$];
  int acc_rep[$];
  int acc_cyc[$];

  key_cmd_sched_if bus ();

  key_cmd_sched #(
    .HOLD_CYC (HOLD),
    .REP_CYC  (REP),
    .CNT_W    (4)
  ) dut (
    .clk50M  (clk50M),
    .rst     (rst),
    .k_n     (k_n),
    .en      (en),
    .cmd     (bus),
    .held    (held),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  initial clk50M = 1'b0;
  always #10 clk50M = ~clk50M;

  // Reference: events derived from the age of each press, plain slots, rotating scan.
  bit [3:0] m_held, m_hprev, m_pend, m_prep, m_ovf;
  bit       m_active[4];
  int       m_age[4];
  bit       m_valid, m_rep;
  bit [1:0] m_key, m_rr;

  always @(posedge clk50M) begin : model
    bit [3:0] evs, evr;
    bit       ld, g_any;
    bit [1:0] g;
    int       kk;
    cyc++;
    if (!rst && bus.cmd_valid && bus.cmd_ready) begin
      acc_key.push_back(int'(bus.cmd_key));
      acc_rep.push_back(int'(bus.cmd_rep));
      acc_cyc.push_back(cyc);
    end
    if (rst) begin
      m_held = 4'hF; m_hprev = 4'hF; m_pend = 0; m_prep = 0; m_ovf = 0;
      m_valid = 0; m_rep = 0; m_key = 0; m_rr = 2'd3;
      for (int k = 0; k < 4; k++) begin m_active[k] = 0; m_age[k] = 0; end
    end else begin
      evs = 0; evr = 0;
      for (int k = 0; k < 4; k++) begin
        if (!en) m_active[k] = 0;
        else if (m_active[k]) begin
          if (!m_held[k]) m_active[k] = 0;
          else begin
            m_age[k]++;
            if (m_age[k] == HOLD || (m_age[k] > HOLD && (m_age[k] - HOLD) % REP == 0)) begin
              evs[k] = 1; evr[k] = 1;
            end
          end
        end else if (m_held[k] && !m_hprev[k]) begin
          evs[k] = 1; m_active[k] = 1; m_age[k] = 0;
        end
      end
      ld = !m_valid || bus.cmd_ready;
      g_any = 0; g = 0;
      if (ld) begin
        for (int i = 1; i <= 4; i++) begin
          kk = (int'(m_rr) + i) % 4;
          if (!g_any && m_pend[kk]) begin g_any = 1; g = 2'(kk); end
        end
        if (g_any) begin
          m_valid = 1; m_key = g; m_rep = m_prep[g]; m_rr = g; m_pend[g] = 0;
        end else m_valid = 0;
      end
      if (ovf_clr) m_ovf = 0;
      for (int k = 0; k < 4; k++) begin
        if (evs[k]) begin
          if (m_pend[k]) m_ovf[k] = 1;
          else begin m_pend[k] = 1; m_prep[k] = evr[k]; end
        end
      end
      m_hprev = m_held;
      m_held  = ~k_n;
    end
  end

  task automatic tick();
    @(posedge clk50M);
    @(negedge clk50M);
  endtask

  task automatic clear_log();
    acc_key.delete();
    acc_rep.delete();
    acc_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; k_n = 4'hF; en = 1'b1; ovf_clr = 1'b0; bus.cmd_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    clear_log();
  endtask

  task automatic test_reset();
    rst = 1'b1; k_n = 4'h0; en = 1'b1; ovf_clr = 1'b0; bus.cmd_ready = 1'b1;
    tick(); tick();
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.cmd_valid); end
    checks++; if (ovf !== 4'h0) begin errors++; $display("[TB] FAIL reset_ovf: got %h expected 0", ovf); end
    checks++; if (held !== 4'hF) begin errors++; $display("[TB] FAIL reset_held: got %h expected f", held); end
    rst = 1'b0;
    repeat (4) tick();
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL held_thru_reset: got valid %b expected 0", bus.cmd_valid); end
    k_n = 4'hF;
    tick();
    checks++; if (held !== 4'h0) begin errors++; $display("[TB] FAIL held_release: got %h expected 0", held); end
    clear_log();
  endtask

  task automatic test_tap();
    do_reset();
    k_n = 4'b1101;
    tick();
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL tap_e0: got valid %b expected 0", bus.cmd_valid); end
    tick();
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL tap_e1: got valid %b expected 0", bus.cmd_valid); end
    tick();
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_key !== 2'd1 || bus.cmd_rep !== 1'b0) begin
      errors++; $display("[TB] FAIL tap_e2: got v=%b k=%0d r=%b expected v=1 k=1 r=0", bus.cmd_valid, bus.cmd_key, bus.cmd_rep);
    end
    k_n = 4'hF;
    tick();
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL tap_e3: got valid %b expected 0", bus.cmd_valid); end
    repeat (6) tick();
    checks++;
    if (acc_key.size() != 1) begin
      errors++; $display("[TB] FAIL tap_count: got %0d commands expected 1", acc_key.size());
    end else if (acc_key[0] != 1 || acc_rep[0] != 0) begin
      errors++; $display("[TB] FAIL tap_cmd: got k=%0d r=%0d expected k=1 r=0", acc_key[0], acc_rep[0]);
    end
  endtask

  task automatic test_hold_repeat();
    int exp_gap[5] = '{HOLD, REP, REP, REP, REP};
    do_reset();
    k_n = 4'b1011;
    repeat (26) tick();
    k_n = 4'hF;
    repeat (12) tick();
    checks++;
    if (acc_key.size() != 6) begin
      errors++; $display("[TB] FAIL hold_count: got %0d commands expected 6", acc_key.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (acc_key[i] != 2 || acc_rep[i] != (i == 0 ? 0 : 1)) begin
          errors++; $display("[TB] FAIL hold_cmd%0d: got k=%0d r=%0d expected k=2 r=%0d", i, acc_key[i], acc_rep[i], (i == 0 ? 0 : 1));
        end
      end
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (acc_cyc[i+1] - acc_cyc[i] != exp_gap[i]) begin
          errors++; $display("[TB] FAIL hold_gap%0d: got %0d expected %0d", i, acc_cyc[i+1] - acc_cyc[i], exp_gap[i]);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    int exp1[3] = '{0, 2, 3};
    int exp2[2] = '{0, 3};
    do_reset();
    k_n = 4'b0010;
    repeat (2) tick();
    k_n = 4'hF;
    repeat (6) tick();
    checks++;
    if (acc_key.size() != 3) begin
      errors++; $display("[TB] FAIL simul_count: got %0d expected 3", acc_key.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (acc_key[i] != exp1[i] || (i > 0 && acc_cyc[i] - acc_cyc[i-1] != 1)) begin
          errors++; $display("[TB] FAIL simul_order%0d: got k=%0d expected k=%0d back-to-back", i, acc_key[i], exp1[i]);
        end
      end
    end
    clear_log();
    k_n = 4'b0110;
    repeat (2) tick();
    k_n = 4'hF;
    repeat (6) tick();
    checks++;
    if (acc_key.size() != 2) begin
      errors++; $display("[TB] FAIL wrap_count: got %0d expected 2", acc_key.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (acc_key[i] != exp2[i]) begin
          errors++; $display("[TB] FAIL wrap_order%0d: got k=%0d expected k=%0d", i, acc_key[i], exp2[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.cmd_ready = 1'b0;
    repeat (3) begin
      k_n = 4'b1110; tick(); tick();
      k_n = 4'hF;    tick(); tick();
    end
    checks++; if (ovf !== 4'b0001) begin errors++; $display("[TB] FAIL ovf_set: got %h expected 1", ovf); end
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_key !== 2'd0 || bus.cmd_rep !== 1'b0) begin
      errors++; $display("[TB] FAIL ovf_stable: got v=%b k=%0d r=%b expected v=1 k=0 r=0", bus.cmd_valid, bus.cmd_key, bus.cmd_rep);
    end
    bus.cmd_ready = 1'b1;
    repeat (6) tick();
    checks++; if (acc_key.size() != 2) begin errors++; $display("[TB] FAIL ovf_drain: got %0d commands expected 2", acc_key.size()); end
    checks++; if (ovf !== 4'b0001) begin errors++; $display("[TB] FAIL ovf_sticky: got %h expected 1", ovf); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (ovf !== 4'h0) begin errors++; $display("[TB] FAIL ovf_clr: got %h expected 0", ovf); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.cmd_ready = 1'b0;
    k_n = 4'b0111;
    repeat (HOLD + REP + 3) tick();
    checks++; if (bus.cmd_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_valid: got %b expected 1", bus.cmd_valid); end
    checks++; if (ovf !== 4'b1000) begin errors++; $display("[TB] FAIL mid_pre_ovf: got %h expected 8", ovf); end
    rst = 1'b1;
    tick();
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid: got %b expected 0", bus.cmd_valid); end
    checks++; if (ovf !== 4'h0) begin errors++; $display("[TB] FAIL mid_rst_ovf: got %h expected 0", ovf); end
    rst = 1'b0;
    bus.cmd_ready = 1'b1;
    repeat (20) tick();
    checks++;
    if (acc_key.size() != 0 || bus.cmd_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_no_stale: got %0d commands valid=%b expected 0", acc_key.size(), bus.cmd_valid);
    end
    k_n = 4'hF;
    tick();
  endtask

  task automatic test_enable();
    do_reset();
    en = 1'b0;
    k_n = 4'b1110; tick(); tick();
    k_n = 4'hF; repeat (4) tick();
    checks++; if (acc_key.size() != 0) begin errors++; $display("[TB] FAIL en_off_tap: got %0d commands expected 0", acc_key.size()); end
    k_n = 4'b1101;
    repeat (3) tick();
    en = 1'b1;
    repeat (20) tick();
    checks++; if (acc_key.size() != 0) begin errors++; $display("[TB] FAIL en_rise_held: got %0d commands expected 0", acc_key.size()); end
    k_n = 4'hF; tick();
    k_n = 4'b1110; tick(); tick();
    k_n = 4'hF; repeat (5) tick();
    checks++;
    if (acc_key.size() != 1 || acc_key[0] != 0) begin
      errors++; $display("[TB] FAIL en_on_tap: got %0d commands expected 1 on key 0", acc_key.size());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 11) == 0) k_n[k] = ~k_n[k];
      end
      bus.cmd_ready = ($urandom_range(0, 1) == 1);
      ovf_clr       = ($urandom_range(0, 15) == 0);
      en            = ($urandom_range(0, 49) != 0);
      rst           = ($urandom_range(0, 599) == 0);
      tick();
      checks++;
      if (bus.cmd_valid !== m_valid) begin
        errors++; $display("[TB] FAIL rnd_valid@%0d: got %b expected %b", c, bus.cmd_valid, m_valid);
      end else if (m_valid && (bus.cmd_key !== m_key || bus.cmd_rep !== m_rep)) begin
        errors++; $display("[TB] FAIL rnd_cmd@%0d: got k=%0d r=%b expected k=%0d r=%b", c, bus.cmd_key, bus.cmd_rep, m_key, m_rep);
      end
      checks++;
      if (ovf !== m_ovf || held !== m_held) begin
        errors++; $display("[TB] FAIL rnd_flags@%0d: got ovf=%h held=%h expected ovf=%h held=%h", c, ovf, held, m_ovf, m_held);
      end
    end
    rst = 1'b0; en = 1'b1; ovf_clr = 1'b0; k_n = 4'hF;
    tick();
  endtask

  initial begin
    rst = 1'b1; k_n = 4'hF; en = 1'b1; ovf_clr = 1'b0; bus.cmd_ready = 1'b1;
    test_reset();
    test_tap();
    test_hold_repeat();
    test_simultaneous();
    test_overflow();
    test_reset_mid();
    test_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
